// File: rtl/prueba_reloj.sv
// prueba_reloj: free-running LED blinker used as a clock/reset sanity
// indicator. A prescaler divides Clock by HALF_PERIOD and emits a one-cycle
// tick. On each tick the LED either toggles (square wave, default build) or
// steps through an 8-phase heartbeat pattern.
//
// Build option: define PRUEBARELOJ_HEARTBEAT_EN to select the heartbeat
// pattern. Without it, the LED is a 50 % duty square wave with a period of
// 2*HALF_PERIOD Clock cycles.
//
// There is no handshake. The block is never idle and never stalled. Led is
// a register output, so it has no combinational path from any input.

module prueba_reloj #(
  parameter int unsigned HALF_PERIOD = 25_000_000,
  parameter int unsigned CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1
) (
  input  logic Clock,
  input  logic Reset,
  output logic Led
);

  // HALF_PERIOD of zero would make the prescaler wrap value meaningless.
  if (HALF_PERIOD == 0) begin : g_bad_half_period
    $error("prueba_reloj: HALF_PERIOD must be at least 1");
  end

  // Terminal count of the prescaler.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_tick;
  logic             r_led;
  logic             w_led_next;

  // Prescaler next value; tick marks the wrap cycle.
  always_comb begin
    w_tick     = (r_cnt == LAST);
    w_cnt_next = w_tick ? '0 : r_cnt + CNT_W'(1);
  end

  // Prescaler register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

`ifdef PRUEBARELOJ_HEARTBEAT_EN
  // Led is lit in phases 1 and 3 of each 8-phase cycle.
  localparam logic [7:0] PATTERN = 8'b0000_1010;

  logic [2:0] r_phase;
  logic [2:0] w_phase_next;

  // Phase advances on tick. Led takes the pattern bit of the new phase on
  // the same edge, so there is no extra latency after the wrap.
  always_comb begin
    w_phase_next = r_phase;
    w_led_next   = r_led;
    if (w_tick) begin
      w_phase_next = r_phase + 3'd1;
      w_led_next   = PATTERN[w_phase_next];
    end
  end

  // Phase register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_phase <= 3'd0;
    end else begin
      r_phase <= w_phase_next;
    end
  end
`else
  // Square wave: flip the LED on every prescaler wrap.
  always_comb begin
    w_led_next = w_tick ? ~r_led : r_led;
  end
`endif

  // LED register. Reset drops the LED without waiting for a Clock edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_led <= 1'b0;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign Led = r_led;

endmodule

// File: tb/tb_prueba_reloj.sv
// Bench for prueba_reloj. Three instances share the clock and the reset:
// HALF_PERIOD = 5, HALF_PERIOD = 1, and the default HALF_PERIOD. Expected
// LED levels come from the edge count since reset release. They are queued
// when each edge is driven and compared on the following falling edge.

module tb_prueba_reloj;

  localparam int unsigned HP_A   = 5;
  localparam int unsigned HP_MIN = 1;
  localparam int unsigned HP_DEF = 25_000_000;

  // Clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic led5;
  logic led1;
  logic ledb;

  always #10 clk = ~clk;

  prueba_reloj #(.HALF_PERIOD(HP_A))   dut5 (.Clock(clk), .Reset(rst_n), .Led(led5));
  prueba_reloj #(.HALF_PERIOD(HP_MIN)) dut1 (.Clock(clk), .Reset(rst_n), .Led(led1));
  prueba_reloj                         dutb (.Clock(clk), .Reset(rst_n), .Led(ledb));

  // Scoreboard state
  logic [0:0] exp_q5[$];
  logic [0:0] exp_q1[$];
  logic [0:0] exp_qb[$];
  int         n;
  int         total;
  int         bad;
  logic [0:0] e5;
  logic [0:0] e1;
  logic [0:0] eb;

  // Reference LED level after edge k (k >= 1) counted from reset release.
  function automatic logic model_led(input int unsigned k, input int unsigned hp);
    int unsigned ph;
    ph = k / hp;
`ifdef PRUEBARELOJ_HEARTBEAT_EN
    return ((ph % 8) == 1) || ((ph % 8) == 3);
`else
    return (ph % 2) == 1;
`endif
  endfunction

  // Driver: advance one rising edge, queue the expected levels, and stop on
  // the falling edge, where outputs are sampled.
  task automatic drive_edge();
    @(posedge clk);
    if (rst_n) begin
      n = n + 1;
      exp_q5.push_back(model_led(n, HP_A));
      exp_q1.push_back(model_led(n, HP_MIN));
      exp_qb.push_back(model_led(n, HP_DEF));
    end else begin
      exp_q5.push_back(1'b0);
      exp_q1.push_back(1'b0);
      exp_qb.push_back(1'b0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_edge();
      e5 = exp_q5.pop_front(); e1 = exp_q1.pop_front(); eb = exp_qb.pop_front();
      total++; if (led5 !== e5) begin bad++; $display("FAIL rst_led5 cyc=%0d got=%b exp=%b", i, led5, e5); end
      total++; if (led1 !== e1) begin bad++; $display("FAIL rst_led1 cyc=%0d got=%b exp=%b", i, led1, e1); end
      total++; if (ledb !== eb) begin bad++; $display("FAIL rst_ledb cyc=%0d got=%b exp=%b", i, ledb, eb); end
      total++; if (dut5.r_cnt !== 3'd0) begin bad++; $display("FAIL rst_cnt cyc=%0d got=%0d exp=0", i, dut5.r_cnt); end
    end
  endtask

  task automatic test_square_wave();
    int   rises;
    int   first_rise;
    int   first_fall;
    int   hi_len;
    int   last_rise;
    int   exp_rises;
    int   exp_gap;
    logic prev;
`ifdef PRUEBARELOJ_HEARTBEAT_EN
    exp_rises = 6;
`else
    exp_rises = 10;
`endif
    rises = 0; first_rise = -1; first_fall = -1; hi_len = 0; last_rise = 0;
    rst_n = 1'b1;
    n = 0;
    prev = led5;
    for (int i = 0; i < 100; i++) begin
      drive_edge();
      e5 = exp_q5.pop_front(); e1 = exp_q1.pop_front(); eb = exp_qb.pop_front();
      total++; if (led5 !== e5) begin bad++; $display("FAIL sq_led5 edge=%0d got=%b exp=%b", n, led5, e5); end
      total++; if (led1 !== e1) begin bad++; $display("FAIL sq_led1 edge=%0d got=%b exp=%b", n, led1, e1); end
      total++; if (ledb !== eb) begin bad++; $display("FAIL sq_ledb edge=%0d got=%b exp=%b", n, ledb, eb); end
      total++; if (dut5.r_cnt !== 3'(n % HP_A)) begin bad++; $display("FAIL sq_cnt edge=%0d got=%0d exp=%0d", n, dut5.r_cnt, n % HP_A); end
      if (!prev && led5) begin
        if (rises > 0) begin
`ifdef PRUEBARELOJ_HEARTBEAT_EN
          exp_gap = (rises % 2 == 1) ? 10 : 30;
`else
          exp_gap = 10;
`endif
          total++; if (n - last_rise != exp_gap) begin bad++; $display("FAIL sq_period edge=%0d got=%0d exp=%0d", n, n - last_rise, exp_gap); end
        end
        if (first_rise < 0) first_rise = n;
        rises++;
        last_rise = n;
        hi_len = 0;
      end
      if (led5) hi_len++;
      if (prev && !led5) begin
        if (first_fall < 0) first_fall = n;
        total++; if (hi_len != 5) begin bad++; $display("FAIL sq_high_len edge=%0d got=%0d exp=5", n, hi_len); end
      end
      prev = led5;
    end
    total++; if (first_rise != 5) begin bad++; $display("FAIL sq_first_rise got=%0d exp=5", first_rise); end
    total++; if (first_fall != 10) begin bad++; $display("FAIL sq_first_fall got=%0d exp=10", first_fall); end
    total++; if (rises != exp_rises) begin bad++; $display("FAIL sq_rise_count got=%0d exp=%0d", rises, exp_rises); end
  endtask

  task automatic test_mid_reset();
    int rise_at;
    // Restart from a clean release so that edge 7 can be located.
    rst_n = 1'b0;
    drive_edge();
    void'(exp_q5.pop_front()); void'(exp_q1.pop_front()); void'(exp_qb.pop_front());
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      drive_edge();
      e5 = exp_q5.pop_front(); e1 = exp_q1.pop_front(); eb = exp_qb.pop_front();
      total++; if (led5 !== e5) begin bad++; $display("FAIL mid_led5 edge=%0d got=%b exp=%b", n, led5, e5); end
      total++; if (led1 !== e1) begin bad++; $display("FAIL mid_led1 edge=%0d got=%b exp=%b", n, led1, e1); end
      total++; if (ledb !== eb) begin bad++; $display("FAIL mid_ledb edge=%0d got=%b exp=%b", n, ledb, eb); end
    end
    total++; if (led5 !== 1'b1) begin bad++; $display("FAIL mid_led_before got=%b exp=1", led5); end
    // Assert reset between edges; the LED must drop before the next edge.
    #3 rst_n = 1'b0;
    #1;
    total++; if (led5 !== 1'b0) begin bad++; $display("FAIL mid_async_led5 got=%b exp=0", led5); end
    total++; if (dut5.r_cnt !== 3'd0) begin bad++; $display("FAIL mid_async_cnt got=%0d exp=0", dut5.r_cnt); end
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      e5 = exp_q5.pop_front(); e1 = exp_q1.pop_front(); eb = exp_qb.pop_front();
      total++; if (led5 !== e5) begin bad++; $display("FAIL mid_hold_led5 cyc=%0d got=%b exp=%b", i, led5, e5); end
      total++; if (led1 !== e1) begin bad++; $display("FAIL mid_hold_led1 cyc=%0d got=%b exp=%b", i, led1, e1); end
    end
    rst_n = 1'b1;
    n = 0;
    rise_at = -1;
    for (int i = 0; i < 8; i++) begin
      drive_edge();
      e5 = exp_q5.pop_front(); e1 = exp_q1.pop_front(); eb = exp_qb.pop_front();
      total++; if (led5 !== e5) begin bad++; $display("FAIL rel_led5 edge=%0d got=%b exp=%b", n, led5, e5); end
      total++; if (ledb !== eb) begin bad++; $display("FAIL rel_ledb edge=%0d got=%b exp=%b", n, ledb, eb); end
      if (led5 === 1'b1 && rise_at < 0) rise_at = n;
    end
    total++; if (rise_at != 5) begin bad++; $display("FAIL rel_rise_edge got=%0d exp=5", rise_at); end
  endtask

  task automatic test_min_divider();
    logic prev1;
    prev1 = led1;
    for (int i = 0; i < 8; i++) begin
      drive_edge();
      e5 = exp_q5.pop_front(); e1 = exp_q1.pop_front(); eb = exp_qb.pop_front();
      total++; if (led1 !== e1) begin bad++; $display("FAIL min_led1 edge=%0d got=%b exp=%b", n, led1, e1); end
      total++; if (led5 !== e5) begin bad++; $display("FAIL min_led5 edge=%0d got=%b exp=%b", n, led5, e5); end
      total++; if (dut1.r_cnt !== 1'b0) begin bad++; $display("FAIL min_cnt edge=%0d got=%0d exp=0", n, dut1.r_cnt); end
`ifndef PRUEBARELOJ_HEARTBEAT_EN
      total++; if (led1 === prev1) begin bad++; $display("FAIL min_toggle edge=%0d got=%b exp=%b", n, led1, ~prev1); end
`endif
      prev1 = led1;
    end
  endtask

  task automatic test_default_smoke();
    for (int i = 0; i < 20; i++) begin
      drive_edge();
      e5 = exp_q5.pop_front(); e1 = exp_q1.pop_front(); eb = exp_qb.pop_front();
      total++; if (ledb !== eb) begin bad++; $display("FAIL def_ledb edge=%0d got=%b exp=%b", n, ledb, eb); end
    end
    total++; if (dutb.r_cnt !== 25'(n % HP_DEF)) begin bad++; $display("FAIL def_cnt got=%0d exp=%0d", dutb.r_cnt, n % HP_DEF); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n     = 0;
    test_reset();
    test_square_wave();
    test_mid_reset();
    test_min_divider();
    test_default_smoke();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prueba_reloj.md
# prueba_reloj

Free-running LED blinker: divides the board clock by a programmable count and drives one LED output. It is the clock-sanity block of the hex-decoder board design, a visible indication that the clock tree and reset are alive. The default build produces a 50 % duty square wave. An optional build produces a heartbeat pattern instead.

## Interface
Parameters:
- `HALF_PERIOD`, default 25_000_000, Clock cycles per LED phase. With 50 MHz Clock this gives a 1 Hz square wave. Legal range 1..2^32-1; a value < 1 is an elaboration error.
- `CNT_W`, default `$clog2(HALF_PERIOD)` (minimum 1), prescaler width. Derived; not overridden.

Ports:
- `Clock`, input, 1, system clock, rising-edge active. This is the only clock.
- `Reset`, input, 1, asynchronous, active-low reset. 0 clears all state immediately; release is sampled on the Clock rising edge.
- `Led`, output, 1, LED drive, 1 = lit. Registered, with no combinational path from any input.

## Operation
- Prescaler `cnt` (CNT_W bits):
  - counts 0..HALF_PERIOD-1;
  - on a Clock edge with cnt == HALF_PERIOD-1 it wraps to 0 and asserts internal one-cycle `tick`;
  - otherwise it increments.
- Square-wave mode (default): on each `tick` edge, Led toggles.
- Heartbeat mode (see Configuration):
  - 3-bit `phase` increments on each `tick` and wraps 7 -> 0.
  - On the same edge, Led <= PATTERN[phase_next], with PATTERN = 8'b0000_1010, so Led is lit in phases 1 and 3.
- Reset state while Reset = 0: cnt = 0, phase = 0, Led = 0.
- Reset asserted mid-count or while Led = 1: all state clears asynchronously and Led drops to 0 without waiting for a Clock edge.
- HALF_PERIOD = 1:
  - tick is asserted on every cycle;
  - in square-wave mode Led = Clock/2;
  - cnt stays 0.
- No other inputs; the block is never idle or stalled.

## Timing
- Reset release: the first Clock rising edge with Reset = 1 is edge 1.
- Square-wave mode:
  - Led goes 0 -> 1 on edge HALF_PERIOD;
  - Led goes 1 -> 0 on edge 2*HALF_PERIOD;
  - period is exactly 2*HALF_PERIOD cycles, duty exactly 50 %, no jitter.
- Heartbeat mode:
  - Led high during edges [HALF_PERIOD, 2*HALF_PERIOD) and [3*HALF_PERIOD, 4*HALF_PERIOD), low otherwise;
  - pattern period is 8*HALF_PERIOD cycles.
- Latency from tick to Led change: 0 extra cycles, because Led updates on the same edge on which cnt wraps.
- All registers update only on the rising edge of Clock, except for asynchronous reset.

## Configuration
- Macro `PRUEBARELOJ_HEARTBEAT_EN`.
- Undefined: square-wave mode. The `phase` register and PATTERN are not synthesized.
- Defined: heartbeat mode as specified above. The toggle logic is not synthesized.
- The prescaler, reset behaviour and port list are identical in both builds.

## Test plan
All scenarios use HALF_PERIOD = 5 and a 20 ns Clock (50 MHz) unless stated otherwise.
- Reset hold: keep Reset = 0 for 10 cycles -> Led = 0 throughout; cnt = 0.
- Square wave: release reset -> Led rises at edge 5 and falls at edge 10; over 100 edges there are 10 rising edges, each high level is exactly 5 cycles and each period exactly 10 cycles.
- Mid-operation reset: assert Reset = 0 at edge 7 while Led = 1, asynchronously between edges -> Led = 0 immediately. On release, Led rises again exactly 5 edges later.
- Minimum divider: HALF_PERIOD = 1 -> Led toggles on every edge, i.e. period 2 cycles.
- Heartbeat build (macro defined): release reset -> Led pattern per 5-cycle phase is 0,1,0,1,0,0,0,0, repeating with a period of 40 cycles.
- Default parameter smoke test: HALF_PERIOD = 25_000_000 -> first Led rise at edge 25_000_000, i.e. 500 ms after reset release.
